rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, such as a decoded one-hot select bus.
- Arbitrates with a rotating-priority pick (priority encode plus 2->4 decode), registers the grant, and holds it until the owner releases.
- Sits between requesting masters and the shared resource; its gnt vector drives the resource select directly.

Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles per owner. Used only when the optional feature is compiled in; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants but does not revoke a current grant.
- req  input  4  request per master, level-sensitive, active high.
- gnt  output  4  one-hot registered grant; all zero when no owner.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_id  output  2  binary index of the owner; 0 when gnt_valid=0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low. While rst_n=0: gnt=0000, gnt_valid=0, gnt_id=00, ptr=00, state=IDLE, hold_cnt=0. Reset takes effect immediately, including mid-grant.
- Pointer: ptr (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4 (wrap 3->0).
- Winner: the first asserted req in search order. Computed combinationally by rotating req by ptr, priority-picking the lowest set bit, and rotating the index back.
- IDLE state, at each edge:
  - en=1 and |req=1: grant the winner; state->BUSY; hold_cnt=0.
  - Otherwise: remain in IDLE with outputs zero.
- Grant latency: gnt asserts on the first edge at which req is sampled high. One-cycle latency from req to gnt.
- BUSY state, at each edge:
  - req[gnt_id]=1: hold the grant; hold_cnt increments, saturating at 255.
  - req[gnt_id]=0: release; ptr = gnt_id+1 mod 4.
  - Same edge as a release, with en=1 and another req set: grant the new winner using the updated ptr. No bubble; state stays BUSY; hold_cnt=0.
  - Release with no other req, or with en=0: gnt=0; state->IDLE.
- Fairness: a continuously requesting master waits at most 3 grant tenures.
- en=0 in BUSY: the current owner keeps its grant until release; no new grant is issued while en=0.
- Simultaneous requests: exactly one bit of gnt is ever set. gnt, gnt_id and gnt_valid always change on the same edge.
- Glitches: a req pulse shorter than one clock between edges is invisible.
- A req asserted for a master that is not the owner has no effect on the current grant.

Optional Feature:
- Macro: RR_ARB_HOLD_LIMIT_EN.
- Defined: in BUSY, when hold_cnt==HOLD_MAX-1, req[gnt_id] is still 1, en=1 and any other req is set, the grant is forcibly rotated on that edge:
  - ptr = gnt_id+1;
  - the new winner (which excludes the old owner) is granted;
  - hold_cnt=0.
  - If no other req is set, the owner keeps the grant and hold_cnt saturates.
- Not defined: hold_cnt and HOLD_MAX are absent; grants are held indefinitely while the owner requests.

Decomposition:
- Shared package dsd_arb_pkg holds:
  - NUM_REQ=4, ID_W=2;
  - state typedef arb_state_t {ARB_IDLE, ARB_BUSY};
  - the HOLD_CNT_W=8 constant.
- One natural sub-module: rr_pick_4, combinational. Inputs req[3:0] and ptr[1:0]; outputs any and win_id[1:0]. Internally it reuses priority_encoder_4to2 on the rotated request. decoder_2to4 converts win_id to one-hot at the register input.

Test Plan:
- Reset: rst_n=0 with req=1111 -> gnt=0000, gnt_valid=0, gnt_id=00. Release rst_n with req=1111 -> one edge later gnt=0001, gnt_id=00.
- Round robin: hold req=1111 and drop each owner's req for one edge after it is granted -> grant order 0,1,2,3,0 with no idle cycle between handoffs.
- Wrap and skip: ptr=3 (after owner 2 releases), req=0011 -> gnt=0001 (index 0 before 1); next release -> gnt=0010.
- Enable gating: owner 1 busy, en=0, req=1110 -> gnt stays 0010. Owner 1 drops req -> gnt=0000, IDLE. en=1 -> next edge gnt=0100.
- Async reset mid-grant: gnt=1000, assert rst_n=0 between edges -> gnt=0000 before the next clock edge. ptr returns to 0.
- RR_ARB_HOLD_LIMIT_EN, HOLD_MAX=4: req=0011 held constant -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, alternating. With req=0001 alone -> gnt=0001 held indefinitely.

Source files
------------

// File: rtl/dsd_arb_pkg.sv
// Shared constants and state type for the round-robin arbiter slice.
// RR_ARB_HOLD_LIMIT_EN enables the hold-limit counter in rr_arbiter_4.
package dsd_arb_pkg;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/decoder_2to4.sv
// Binary index to one-hot select.
module decoder_2to4 (
  input  logic [1:0] idx,
  output logic [3:0] onehot
);
  assign onehot = 4'b0001 << idx;
endmodule

// File: rtl/priority_encoder_4to2.sv
// Lowest-index-wins priority encoder; idx is 0 when nothing is set.
module priority_encoder_4to2 (
  input  logic [3:0] in,
  output logic       any,
  output logic [1:0] idx
);
  always_comb begin
    idx = '0;
    any = |in;
    for (int i = 3; i >= 0; i--)
      if (in[i]) idx = 2'(i);
  end
endmodule

// File: rtl/rr_pick_4.sv
// Rotating-priority pick: first set req starting at ptr, wrapping 3->0.
module rr_pick_4 import dsd_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    win_id
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      rot_idx;

  // rot[i] = req[(i+ptr) mod 4], so the lowest set bit of rot is the winner
  assign dbl = {req, req};
  assign rot = dbl[ptr +: NUM_REQ];

  priority_encoder_4to2 u_pe (
    .in  (rot),
    .any (any),
    .idx (rot_idx)
  );

  assign win_id = rot_idx + ptr;
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Define RR_ARB_HOLD_LIMIT_EN to force rotation after HOLD_MAX held cycles.
module rr_arbiter_4 import dsd_arb_pkg::*;
`ifdef RR_ARB_HOLD_LIMIT_EN
#(
  parameter int HOLD_MAX = 8
)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);
  arb_state_t         state, state_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [ID_W-1:0]    id_q, id_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [NUM_REQ-1:0] pick_req;
  logic [ID_W-1:0]    pick_ptr, win_id, next_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic               pick_any, owner_req;

  // While busy, search from owner+1 and exclude the owner: this serves both
  // a release (owner bit already low) and a forced rotation.
  assign next_ptr  = id_q + 2'd1;
  assign pick_req  = req & ~gnt_q;
  assign pick_ptr  = (state == ARB_BUSY) ? next_ptr : ptr;
  assign owner_req = req[id_q];

  rr_pick_4 u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .win_id (win_id)
  );

  decoder_2to4 u_dec (
    .idx    (win_id),
    .onehot (win_oh)
  );

`ifdef RR_ARB_HOLD_LIMIT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_n, hold_inc;
  logic                  hold_expired;

  assign hold_inc     = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
  assign hold_expired = (hold_cnt == HOLD_CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_n;
  end
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    id_n    = id_q;
    gnt_n   = gnt_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_n  = hold_cnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (en && pick_any) begin
          state_n = ARB_BUSY;
          id_n    = win_id;
          gnt_n   = win_oh;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_n  = '0;
`endif
        end
      end
      ARB_BUSY: begin
        if (owner_req) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (hold_expired && en && pick_any) begin
            ptr_n  = next_ptr;
            id_n   = win_id;
            gnt_n  = win_oh;
            hold_n = '0;
          end else begin
            hold_n = hold_inc;
          end
`endif
        end else begin
          ptr_n = next_ptr;
          if (en && pick_any) begin
            id_n   = win_id;
            gnt_n  = win_oh;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_n = '0;
`endif
          end else begin
            state_n = ARB_IDLE;
            id_n    = '0;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        id_n    = '0;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      id_q  <= '0;
      gnt_q <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      id_q  <= id_n;
      gnt_q <= gnt_n;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state == ARB_BUSY);
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed + randomized bench for rr_arbiter_4 against an integer-level model.
module tb_rr_arbiter_4;
  logic       clk, rst_n, en;
  logic [3:0] req, gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  int checks = 0;
  int fails  = 0;

  // model: owner index (-1 = none), priority pointer, held-cycle count
  int own, mptr, mhold;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HM = 4;
  rr_arbiter_4 #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id));
`else
  rr_arbiter_4 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int first_req(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1; mptr = 0; mhold = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic e);
    if (own < 0) begin
      if (e && r != 4'b0) begin own = first_req(r, mptr); mhold = 0; end
    end else if (r[own]) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
      logic [3:0] others;
      others = r;
      others[own] = 1'b0;
      if (mhold == HM - 1 && e && others != 4'b0) begin
        mptr  = (own + 1) % 4;
        own   = first_req(others, mptr);
        mhold = 0;
      end else if (mhold < 255) mhold++;
`else
      if (mhold < 255) mhold++;
`endif
    end else begin
      mptr = (own + 1) % 4;
      if (e && r != 4'b0) begin own = first_req(r, mptr); mhold = 0; end
      else own = -1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    eg = (own < 0) ? 4'b0 : (4'b0001 << own);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".valid"}, {3'b0, gnt_valid}, {3'b0, own >= 0});
    chk({tag, ".id"}, {2'b0, gnt_id}, (own < 0) ? 4'b0 : 4'(own));
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic e);
    req = r; en = e;
    @(posedge clk);
    model_edge(r, e);
    #1;
    chk_model(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"}, gnt, 4'b0000);
    chk({tag, ".valid"}, {3'b0, gnt_valid}, 4'b0);
    chk({tag, ".id"}, {2'b0, gnt_id}, 4'b0);
  endtask

  initial begin
    logic [3:0] r;
    logic       e;
    rst_n = 1'b0; en = 1'b1; req = 4'b1111;
    model_reset();
    #3;
    chk_zero("reset");
    @(negedge clk); @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1;

    step("first_grant", 4'b1111, 1'b1);
    chk("first_grant_lit", gnt, 4'b0001);

    // round robin with one-edge drop by each owner
    step("rr1", 4'b1110, 1'b1); chk("rr1_lit", gnt, 4'b0010);
    step("rr2", 4'b1101, 1'b1); chk("rr2_lit", gnt, 4'b0100);
    step("rr3", 4'b1011, 1'b1); chk("rr3_lit", gnt, 4'b1000);
    step("rr0", 4'b0111, 1'b1); chk("rr0_lit", gnt, 4'b0001);

    // wrap and skip: owner 2 releases with ptr landing on 3
    step("to2",   4'b0100, 1'b1); chk("to2_lit", gnt, 4'b0100);
    step("wrap",  4'b0011, 1'b1); chk("wrap_lit", gnt, 4'b0001);
    step("skip",  4'b0010, 1'b1); chk("skip_lit", gnt, 4'b0010);

    // enable gating
    step("en_hold", 4'b1110, 1'b0); chk("en_hold_lit", gnt, 4'b0010);
    step("en_rel",  4'b1100, 1'b0); chk("en_rel_lit", gnt, 4'b0000);
    step("en_on",   4'b1100, 1'b1); chk("en_on_lit", gnt, 4'b0100);

    // async reset mid-grant
    step("to3", 4'b1000, 1'b1); chk("to3_lit", gnt, 4'b1000);
    #2; rst_n = 1'b0; model_reset();
    #1; chk_zero("async_rst");
    @(negedge clk); rst_n = 1'b1;
    step("ptr_back", 4'b1111, 1'b1); chk("ptr_back_lit", gnt, 4'b0001);

    // long constant request patterns exercise holding (and rotation when enabled)
    for (int i = 0; i < 12; i++) step("const2", 4'b0011, 1'b1);
    for (int i = 0; i < 8; i++)  step("const1", 4'b0001, 1'b1);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0; model_reset();
        #1; chk_zero("rand_rst");
        @(negedge clk); rst_n = 1'b1;
      end
      r = 4'($urandom);
      if (own >= 0 && $urandom_range(0, 99) < 85) r[own] = 1'b1;
      e = ($urandom_range(0, 99) < 80);
      step("rand", r, e);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
